// File: rtl/systolic_feed_controller_if.sv
// Host/array-side signal bundle for systolic_feed_controller.
// The controller uses the slave modport; the host/bench uses master.
interface systolic_feed_controller_if #(
    parameter int N     = 3,
    parameter int K     = 3,
    parameter int SEL_W = 2,
    parameter int CW    = $clog2(K + N)
);
    logic             start;
    logic [SEL_W-1:0] sel_in;
    logic             abort;
    logic             busy;
    logic             done;
    logic [SEL_W-1:0] sel_out;
    logic             pe_clear;
    logic [CW-1:0]    feed_t;
    logic [N-1:0]     row_en;
    logic [N-1:0]     col_en;

    modport master (
        output start, sel_in, abort,
        input  busy, done, sel_out, pe_clear, feed_t, row_en, col_en
    );

    modport slave (
        input  start, sel_in, abort,
        output busy, done, sel_out, pe_clear, feed_t, row_en, col_en
    );
endinterface

// File: rtl/systolic_feed_controller.sv
// Sequencer for one N x N systolic matrix product: clear, skewed feed, drain, done.
// All outputs are registered from next-state values (Moore).

// Per-lane feed window: lane IDX is active for steps IDX .. IDX+K-1.
module sfc_lane_en #(
    parameter int IDX = 0,
    parameter int K   = 1,
    parameter int CW  = 2
) (
    input  logic          feed,
    input  logic [CW-1:0] t,
    output logic          en
);
    assign en = feed && (int'(t) >= IDX) && (int'(t) < IDX + K);
endmodule

module systolic_feed_controller #(
    parameter int N     = 3,
    parameter int K     = 3,
    parameter int SEL_W = 2,
    parameter int CW    = $clog2(K + N)
) (
    input  logic clk,
    input  logic reset,
    systolic_feed_controller_if.slave bus
);
    localparam int LAST_T = K + N - 2;
    localparam int DW     = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    feed_t, t_n;
    logic [DW-1:0]    dcnt, dcnt_n;
    logic [SEL_W-1:0] sel_q, sel_n;
    logic             busy_q, done_q, clr_q;
    logic [N-1:0]     en_q, en_n;
    logic             feed_n;

    always_comb begin
        state_n = state;
        t_n     = feed_t;
        dcnt_n  = dcnt;
        sel_n   = sel_q;
        case (state)
            IDLE: if (bus.start && !bus.abort) begin
                state_n = CLEAR;
                sel_n   = bus.sel_in;
            end
            CLEAR: begin
                state_n = FEED;
                t_n     = '0;
            end
            FEED: if (feed_t == CW'(LAST_T)) begin
                state_n = DRAIN;
                t_n     = '0;
                dcnt_n  = '0;
            end else begin
                t_n = feed_t + 1'b1;
            end
            DRAIN: if (dcnt == DW'(N - 1)) state_n = DONE;
                   else dcnt_n = dcnt + 1'b1;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Cancel only bites while a job is actually in flight.
        if (bus.abort && (state == CLEAR || state == FEED || state == DRAIN)) begin
            state_n = IDLE;
            t_n     = '0;
            dcnt_n  = '0;
        end
    end

    assign feed_n = (state_n == FEED);

    // Row and column share the same one-cycle-per-index skew.
    for (genvar i = 0; i < N; i++) begin : g_lane
        sfc_lane_en #(.IDX(i), .K(K), .CW(CW)) u_lane (
            .feed (feed_n),
            .t    (t_n),
            .en   (en_n[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            feed_t <= '0;
            dcnt   <= '0;
            sel_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            clr_q  <= 1'b0;
            en_q   <= '0;
        end else begin
            state  <= state_n;
            feed_t <= t_n;
            dcnt   <= dcnt_n;
            sel_q  <= sel_n;
            busy_q <= (state_n == CLEAR) || (state_n == FEED) || (state_n == DRAIN);
            done_q <= (state_n == DONE);
            clr_q  <= (state_n == CLEAR);
            en_q   <= en_n;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sel_out  = sel_q;
    assign bus.pe_clear = clr_q;
    assign bus.feed_t   = feed_t;
    assign bus.row_en   = en_q;
    assign bus.col_en   = en_q;
endmodule

// File: tb/tb_systolic_feed_controller.sv
// Bench for systolic_feed_controller: scoreboarded jobs on N=K=3 plus N=2/K=1 and N=4/K=6 sweeps.
module tb_systolic_feed_controller;
    localparam int N = 3, K = 3, SEL_W = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    systolic_feed_controller_if #(.N(N), .K(K), .SEL_W(SEL_W)) bus ();
    systolic_feed_controller_if #(.N(2), .K(1), .SEL_W(SEL_W)) bus2 ();
    systolic_feed_controller_if #(.N(4), .K(6), .SEL_W(SEL_W)) bus4 ();

    systolic_feed_controller #(.N(N), .K(K), .SEL_W(SEL_W)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));
    systolic_feed_controller #(.N(2), .K(1), .SEL_W(SEL_W)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave));
    systolic_feed_controller #(.N(4), .K(6), .SEL_W(SEL_W)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4.slave));

    typedef struct {
        logic [SEL_W-1:0] sel;
        int               due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) tick();
    endtask

    // Called #1 after a posedge; returns in the CLEAR cycle of the accepted job.
    task automatic start_job(input logic [SEL_W-1:0] s, input bit track);
        bus.start  = 1'b1;
        bus.sel_in = s;
        tick();
        bus.start = 1'b0;
        if (track) sb.push_back('{s, cyc + K + 2 * N});
    endtask

    // Scoreboard: every done must match the oldest outstanding job, on time.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) chk("spurious_done", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.due);
                    chk("done_sel", 32'(bus.sel_out), 32'(e.sel));
                    chk("done_busy", 32'(bus.busy), 32'd0);
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                e = sb.pop_front();
                chk("missed_done", cyc, e.due);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] skew [5];
        int cc, c, d2, d4;
        int c2 [2];
        int c4 [4];
        skew = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100};

        bus.start  = 0; bus.sel_in  = 0; bus.abort  = 0;
        bus2.start = 0; bus2.sel_in = 0; bus2.abort = 0;
        bus4.start = 0; bus4.sel_in = 0; bus4.abort = 0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_clr", 32'(bus.pe_clear), 0);
        chk("rst_sel", 32'(bus.sel_out), 0);
        chk("rst_t", 32'(bus.feed_t), 0);
        chk("rst_en", 32'({bus.row_en, bus.col_en}), 0);
        @(negedge clk) reset = 1'b1;
        tick();

        // Basic job with skew checks
        start_job(2'b01, 1'b1);
        @(negedge clk);
        chk("t1_clear", 32'(bus.pe_clear), 1);
        chk("t1_busy_clr", 32'(bus.busy), 1);
        chk("t1_en_clr", 32'(bus.row_en), 0);
        chk("t1_sel", 32'(bus.sel_out), 1);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("t2_feed_t", 32'(bus.feed_t), 32'(t));
            chk("t2_row_en", 32'(bus.row_en), 32'(skew[t]));
            chk("t2_col_en", 32'(bus.col_en), 32'(skew[t]));
            chk("t2_clr_low", 32'(bus.pe_clear), 0);
        end
        for (int d = 0; d < 3; d++) begin
            @(negedge clk);
            chk("t1_drain_en", 32'({bus.row_en, bus.col_en}), 0);
            chk("t1_drain_busy", 32'(bus.busy), 1);
            chk("t1_drain_done", 32'(bus.done), 0);
        end
        @(negedge clk);
        chk("t1_done", 32'(bus.done), 1);
        tick();
        @(negedge clk);
        chk("t1_idle_busy", 32'(bus.busy), 0);
        chk("t1_sel_hold", 32'(bus.sel_out), 1);

        // start held high: one job per IDLE visit
        tick();
        bus.start  = 1'b1;
        bus.sel_in = 2'b10;
        tick();
        cc = cyc;
        sb.push_back('{2'b10, cc + K + 2 * N});
        bus.sel_in = 2'b11;
        wait_cyc(cc + 5);
        @(negedge clk);
        chk("t3_sel_hold", 32'(bus.sel_out), 2);
        sb.push_back('{2'b11, cc + 11 + K + 2 * N});
        wait_cyc(cc + 10);
        @(negedge clk);
        chk("t3_gap_clr", 32'(bus.pe_clear), 0);
        chk("t3_gap_busy", 32'(bus.busy), 0);
        wait_cyc(cc + 11);
        @(negedge clk);
        chk("t3_reclear", 32'(bus.pe_clear), 1);
        chk("t3_sel2", 32'(bus.sel_out), 3);
        tick();
        bus.start = 1'b0;
        wait_cyc(cc + 22);
        @(negedge clk);
        chk("t3_no_third", 32'(bus.busy), 0);

        // abort at feed_t = 2
        tick();
        start_job(2'b10, 1'b0);
        tick(3);
        @(negedge clk);
        chk("t4_pre_t", 32'(bus.feed_t), 2);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        @(negedge clk);
        chk("t4_busy", 32'(bus.busy), 0);
        chk("t4_en", 32'({bus.row_en, bus.col_en}), 0);
        chk("t4_clr", 32'(bus.pe_clear), 0);
        tick(12);
        start_job(2'b11, 1'b1);
        tick(12);

        // async reset mid-DRAIN
        start_job(2'b01, 1'b1);
        tick(7);
        #2 reset = 1'b0;
        #1;
        chk("t5_busy", 32'(bus.busy), 0);
        chk("t5_done", 32'(bus.done), 0);
        chk("t5_sel", 32'(bus.sel_out), 0);
        chk("t5_outs", 32'({bus.pe_clear, bus.feed_t, bus.row_en, bus.col_en}), 0);
        sb.delete();
        #20;
        @(negedge clk) reset = 1'b1;
        tick(15);
        chk("t5_idle", 32'(bus.busy), 0);

        // parameter sweep
        d2 = -1; d4 = -1;
        c2 = '{0, 0};
        c4 = '{0, 0, 0, 0};
        bus2.start = 1'b1;
        bus4.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        bus4.start = 1'b0;
        c = cyc;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus2.done && d2 < 0) d2 = cyc - c;
            if (bus4.done && d4 < 0) d4 = cyc - c;
            for (int j = 0; j < 2; j++) c2[j] += int'(bus2.row_en[j]);
            for (int j = 0; j < 4; j++) c4[j] += int'(bus4.row_en[j]);
        end
        chk("t6_lat_n2k1", d2, 2 * 2 + 1);
        chk("t6_lat_n4k6", d4, 2 * 4 + 6);
        for (int j = 0; j < 2; j++) chk("t6_rowcnt_n2", c2[j], 1);
        for (int j = 0; j < 4; j++) chk("t6_rowcnt_n4", c4[j], 6);

        tick();
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
